// File: rtl/mem_arb.sv
// Arbiter sharing one single-port memory between the fetch (I) and data (D) ports.
// Define ARB_FAIR_EN for alternating grants on conflicts; default is fixed D-over-I priority.
module mem_arb #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sel_d_q, sel_d_d;  // 1: data port owns the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;

`ifdef ARB_FAIR_EN
  logic last_d_q, last_d_d;

  // last_d_q only moves on a conflict that is actually granted
  always_comb begin
    last_d_d = last_d_q;
    pick_d   = d_req;
    if (i_req && d_req) begin
      pick_d = !last_d_q;
      if (state_q == StIdle) begin
        last_d_d = !last_d_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d_d   = sel_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          sel_d_d = pick_d;
          we_d    = pick_d && d_we;
          addr_d  = pick_d ? d_addr : i_addr;
          wdata_d = pick_d ? d_wdata : '0;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (sel_d_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_d_q   <= sel_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == StBusy);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdy     = (state_q == StDone) && !sel_d_q;
  assign d_rdy     = (state_q == StDone) && sel_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized scoreboard bench for mem_arb: a transaction-level model predicts grants, timing and
// data; a negedge monitor compares the DUT against it. Honours ARB_FAIR_EN like the design.
module tb_mem_arb;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req, d_req, d_we, i_rdy, d_rdy, mem_en, mem_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdy    (i_rdy),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdy    (d_rdy),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          port;   // 0 = I, 1 = D
    int          cyc;    // cycle in which rdy must pulse
    bit          we;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  // Driver state (index 0 = I, 1 = D)
  logic          req_v [2];
  logic [AW-1:0] addr_v [2];
  logic [AW-1:0] orig_addr [2];
  bit            pend [2];
  bit            granted [2];
  int            done_cyc [2];
  logic          dwe_v;
  logic [DW-1:0] dwd_v;

  assign i_req   = req_v[0];
  assign i_addr  = addr_v[0];
  assign d_req   = req_v[1];
  assign d_addr  = addr_v[1];
  assign d_we    = dwe_v;
  assign d_wdata = dwd_v;

  // Reference model state
  int            cyc = 0;
  int            free_cyc = 1 << 30;
  int            busy_s = 0;
  int            busy_e = -1;
  logic [AW-1:0] cur_addr;
  bit            cur_we;
  logic [DW-1:0] cur_wdata;
  bit            last_d;
  logic [DW-1:0] ref_mem [16];

  // Environment memory, owned by the monitor process
  logic [DW-1:0] env_mem [16];
  assign mem_rdata = env_mem[mem_addr[3:0]];

  int total = 0;
  int bad = 0;

  function automatic logic [DW-1:0] seed(input int k);
    return 16'hC3A5 ^ 16'(k * 4369);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input int pct);
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && done_cyc[p] == cyc) pend[p] = 1'b0;
      if (!pend[p]) begin
        if (int'($urandom_range(99)) < pct) begin
          pend[p]      = 1'b1;
          granted[p]   = 1'b0;
          addr_v[p]    = 16'($urandom);
          orig_addr[p] = addr_v[p];
          req_v[p]     = 1'b1;
          if (p == 1) begin
            dwe_v = ($urandom_range(2) == 0);
            dwd_v = 16'($urandom);
          end
        end else begin
          req_v[p] = 1'b0;
        end
      end else if (granted[p] && $urandom_range(3) == 0) begin
        // Dropping req / moving addr after grant must not disturb the access
        req_v[p]  = 1'b0;
        addr_v[p] = 16'($urandom);
      end
    end
  endtask

  task automatic model();
    int   p;
    exp_t e;
    if (cyc >= free_cyc && (req_v[0] || req_v[1])) begin
      p = req_v[1] ? 1 : 0;
`ifdef ARB_FAIR_EN
      if (req_v[0] && req_v[1]) begin
        p      = last_d ? 0 : 1;
        last_d = (p == 1);
      end
`endif
      cur_addr  = orig_addr[p];
      cur_we    = (p == 1) && dwe_v;
      cur_wdata = dwd_v;
      busy_s    = cyc + 1;
      busy_e    = cyc + int'(LAT);
      free_cyc  = cyc + int'(LAT) + 2;
      e.port    = p;
      e.cyc     = cyc + int'(LAT) + 1;
      e.we      = cur_we;
      e.rdata   = cur_we ? '0 : ref_mem[cur_addr[3:0]];
      if (cur_we) ref_mem[cur_addr[3:0]] = cur_wdata;
      sb.push_back(e);
      granted[p]  = 1'b1;
      done_cyc[p] = e.cyc;
    end
  endtask

  task automatic step(input int pct);
    tick();
    drive(pct);
    model();
  endtask

  // Monitor: compares outputs each negedge, and immediately on an asynchronous reset
  initial begin
    logic [DW-1:0] exp_ird, exp_drd;
    bit            exp_i, exp_d, en_exp;
    exp_ird = '0;
    exp_drd = '0;
    for (int k = 0; k < 16; k++) env_mem[k] = seed(k);
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk) begin
        #1;
        exp_ird = '0;
        exp_drd = '0;
      end
      if (!rst_n) begin
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdy", 32'({i_rdy, d_rdy}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
      end else begin
        en_exp = (cyc >= busy_s) && (cyc <= busy_e);
        chk("mem_en", 32'(mem_en), 32'(en_exp));
        if (en_exp) begin
          chk("mem_addr", 32'(mem_addr), 32'(cur_addr));
          chk("mem_we", 32'(mem_we), 32'(cur_we));
          if (cur_we) begin
            chk("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
            env_mem[mem_addr[3:0]] = mem_wdata;
          end
        end
        exp_i = 1'b0;
        exp_d = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          if (sb[0].port == 1) begin
            exp_d = 1'b1;
            if (!sb[0].we) exp_drd = sb[0].rdata;
          end else begin
            exp_i = 1'b1;
            exp_ird = sb[0].rdata;
          end
          void'(sb.pop_front());
        end
        chk("i_rdy", 32'(i_rdy), 32'(exp_i));
        chk("d_rdy", 32'(d_rdy), 32'(exp_d));
        chk("i_rdata", 32'(i_rdata), 32'(exp_ird));
        chk("d_rdata", 32'(d_rdata), 32'(exp_drd));
      end
    end
  end

  initial begin
    bit found;
    for (int k = 0; k < 16; k++) ref_mem[k] = seed(k);
    for (int p = 0; p < 2; p++) begin
      req_v[p]     = 1'b0;
      addr_v[p]    = '0;
      orig_addr[p] = '0;
      pend[p]      = 1'b0;
      granted[p]   = 1'b0;
      done_cyc[p]  = -1;
    end
    dwe_v  = 1'b0;
    dwd_v  = '0;
    last_d = 1'b0;
    repeat (3) tick();
    rst_n    = 1'b1;
    free_cyc = cyc;
    drive(40);
    model();

    repeat (800) step(40);
    repeat (200) step(100);
    repeat (300) step(15);

    // Reset in the middle of a read access; held requests are re-arbitrated afterwards
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      step(60);
      if (cyc >= busy_s && cyc <= busy_e && !cur_we) found = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    busy_s   = 0;
    busy_e   = -1;
    free_cyc = 1 << 30;
    last_d   = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (pend[p]) begin
        req_v[p]   = 1'b1;
        addr_v[p]  = orig_addr[p];
        granted[p] = 1'b0;
        done_cyc[p] = -1;
      end
    end
    tick();
    tick();
    rst_n    = 1'b1;
    free_cyc = cyc;
    drive(60);
    model();

    repeat (400) step(50);
    repeat (200) step(100);
    repeat (20) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
